// File: rtl/hzc_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: forward-select
// encoding, per-stage control flags and the dependency-match helper.
package hzc_pkg;

  // Operand source for the ALU forwarding muxes.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  // Control flags carried by every shadow stage record. The register-index
  // fields depend on RW, so modules wrap this in their own record typedefs.
  typedef struct packed {
    logic valid;
    logic wr;
    logic load;
  } stage_flags_t;

  // A producer record satisfies a consumer source when it is a real register
  // write of that index, the source is really read, and the write is not to a
  // hardwired-zero r0.
  function automatic logic hzc_match(input logic valid, input logic wr,
                                     input logic used, input logic rd_eq,
                                     input logic rd_zero, input logic r0_zero);
    return valid & wr & used & rd_eq & !(r0_zero & rd_zero);
  endfunction

endpackage

// File: rtl/hzc_fwd_sel.sv
// Per-operand forwarding selector: compares one EX source index against the
// MEM and WB shadow records and picks the youngest non-load producer.
module hzc_fwd_sel
  import hzc_pkg::*;
#(
  parameter int RW      = 4,
  parameter int R0_ZERO = 1
) (
  input  logic [RW-1:0] i_src,
  input  logic          i_src_used,
  input  stage_flags_t  i_mem_f,
  input  logic [RW-1:0] i_mem_rd,
  input  logic          i_wb_valid,
  input  logic          i_wb_wr,
  input  logic [RW-1:0] i_wb_rd,
  output fwd_sel_e      o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // MEM beats WB; a load in MEM has no data yet, so it is never a source.
  always_comb begin
    w_mem_hit = hzc_match(i_mem_f.valid, i_mem_f.wr, i_src_used,
                          i_mem_rd == i_src, i_mem_rd == '0, R0_ZERO != 0)
                & !i_mem_f.load;
    w_wb_hit  = hzc_match(i_wb_valid, i_wb_wr, i_src_used,
                          i_wb_rd == i_src, i_wb_rd == '0, R0_ZERO != 0);
    o_sel = FWD_REG;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the pipelined CPU. Keeps shadow records
// of EX/MEM/WB, detects load-use and decode-branch hazards, sequences
// multi-cycle EX ops and drives the forwarding muxes.
// Optional: define HZC_PERF_EN to build saturating stall/flush counters.
module pipe_hazard_ctrl
  import hzc_pkg::*;
#(
  parameter int NREGS   = 16,
  parameter int RW      = $clog2(NREGS),
  parameter int MC_LAT  = 3,
  parameter int R0_ZERO = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [RW-1:0] id_rd,
  input  logic          id_wr,
  input  logic          id_load,
  input  logic          id_mc,
  input  logic          id_branch,
  input  logic          id_taken,
  output logic          stall_if,
  output logic          bubble_ex,
  output logic          flush_id,
  output logic          ex_hold,
  output logic [1:0]    fwd_a_sel,
  output logic [1:0]    fwd_b_sel,
  output logic          mc_busy,
  output logic [31:0]   perf_stalls,
  output logic [31:0]   perf_flushes
);

  localparam int CW = $clog2(MC_LAT);

  typedef struct packed {
    stage_flags_t  f;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          rs1_used;
    logic          rs2_used;
  } ex_rec_t;

  typedef struct packed {
    stage_flags_t  f;
    logic [RW-1:0] rd;
  } mem_rec_t;

  // The load flag is dropped at WB: once data is on the WB bus a load result
  // forwards exactly like an ALU result.
  typedef struct packed {
    logic          valid;
    logic          wr;
    logic [RW-1:0] rd;
  } wb_rec_t;

  ex_rec_t       r_ex;
  mem_rec_t      r_mem;
  wb_rec_t       r_wb;
  logic [CW-1:0] r_mc_cnt;

  ex_rec_t  w_ex_next;
  logic     w_hold;
  logic     w_ex_match;
  logic     w_mem_match;
  logic     w_load_use;
  logic     w_branch_hz;
  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;

  // Hazard detection against the ID sources; multi-cycle hold overrides all.
  always_comb begin
    w_hold      = (r_mc_cnt != '0);
    w_ex_match  = hzc_match(r_ex.f.valid, r_ex.f.wr, id_rs1_used, r_ex.rd == id_rs1,
                            r_ex.rd == '0, R0_ZERO != 0)
                | hzc_match(r_ex.f.valid, r_ex.f.wr, id_rs2_used, r_ex.rd == id_rs2,
                            r_ex.rd == '0, R0_ZERO != 0);
    w_mem_match = hzc_match(r_mem.f.valid, r_mem.f.wr, id_rs1_used, r_mem.rd == id_rs1,
                            r_mem.rd == '0, R0_ZERO != 0)
                | hzc_match(r_mem.f.valid, r_mem.f.wr, id_rs2_used, r_mem.rd == id_rs2,
                            r_mem.rd == '0, R0_ZERO != 0);
    w_load_use  = id_valid & r_ex.f.load & w_ex_match;
    w_branch_hz = id_valid & id_branch & (w_ex_match | (r_mem.f.load & w_mem_match));
    ex_hold     = w_hold;
    mc_busy     = w_hold;
    stall_if    = w_hold | w_load_use | w_branch_hz;
    bubble_ex   = !w_hold & (w_load_use | w_branch_hz);
    // Reset gating keeps flush low while the controller is held in reset.
    flush_id    = reset & id_valid & id_branch & id_taken & !stall_if;
  end

  // Record that enters EX when the pipe advances.
  always_comb begin
    w_ex_next = '0;
    if (id_valid && !bubble_ex) begin
      w_ex_next.f.valid  = 1'b1;
      w_ex_next.f.wr     = id_wr;
      w_ex_next.f.load   = id_load;
      w_ex_next.rd       = id_rd;
      w_ex_next.rs1      = id_rs1;
      w_ex_next.rs2      = id_rs2;
      w_ex_next.rs1_used = id_rs1_used;
      w_ex_next.rs2_used = id_rs2_used;
    end
  end

  // Shadow pipeline and multi-cycle counter; during a hold EX is frozen and
  // a bubble drains into MEM each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_mc_cnt <= '0;
    end else if (w_hold) begin
      r_wb     <= '{valid: r_mem.f.valid, wr: r_mem.f.wr, rd: r_mem.rd};
      r_mem    <= '0;
      r_mc_cnt <= r_mc_cnt - CW'(1);
    end else begin
      r_wb  <= '{valid: r_mem.f.valid, wr: r_mem.f.wr, rd: r_mem.rd};
      r_mem <= '{f: r_ex.f, rd: r_ex.rd};
      r_ex  <= w_ex_next;
      if (w_ex_next.f.valid && id_mc) r_mc_cnt <= CW'(MC_LAT - 1);
    end
  end

  hzc_fwd_sel #(.RW(RW), .R0_ZERO(R0_ZERO)) u_fwd_a (
    .i_src      (r_ex.rs1),
    .i_src_used (r_ex.f.valid & r_ex.rs1_used),
    .i_mem_f    (r_mem.f),
    .i_mem_rd   (r_mem.rd),
    .i_wb_valid (r_wb.valid),
    .i_wb_wr    (r_wb.wr),
    .i_wb_rd    (r_wb.rd),
    .o_sel      (w_fwd_a)
  );

  hzc_fwd_sel #(.RW(RW), .R0_ZERO(R0_ZERO)) u_fwd_b (
    .i_src      (r_ex.rs2),
    .i_src_used (r_ex.f.valid & r_ex.rs2_used),
    .i_mem_f    (r_mem.f),
    .i_mem_rd   (r_mem.rd),
    .i_wb_valid (r_wb.valid),
    .i_wb_wr    (r_wb.wr),
    .i_wb_rd    (r_wb.rd),
    .o_sel      (w_fwd_b)
  );

  assign fwd_a_sel = w_fwd_a;
  assign fwd_b_sel = w_fwd_b;

`ifdef HZC_PERF_EN
  logic [31:0] r_perf_stalls;
  logic [31:0] r_perf_flushes;

  // Saturating counts of stall and flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stalls  <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (stall_if && (r_perf_stalls != '1))  r_perf_stalls  <= r_perf_stalls + 32'd1;
      if (flush_id && (r_perf_flushes != '1)) r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign perf_stalls  = r_perf_stalls;
  assign perf_flushes = r_perf_flushes;
`else
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (NREGS=16, MC_LAT=3, R0_ZERO=1).
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_rs1_used, id_rs2_used, id_wr, id_load, id_mc;
  logic        id_branch, id_taken;
  logic [3:0]  id_rs1, id_rs2, id_rd;
  logic        stall_if, bubble_ex, flush_id, ex_hold, mc_busy;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] perf_stalls, perf_flushes;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NREGS(16), .MC_LAT(3), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .id_mc(id_mc),
    .id_branch(id_branch), .id_taken(id_taken),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .ex_hold(ex_hold), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mc_busy(mc_busy), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
  );

  // Present one decode-stage instruction, then let combinational outputs settle.
  task automatic id_ins(input int v, input int rs1, input int u1, input int rs2,
                        input int u2, input int rd, input int wr, input int ld,
                        input int mc, input int br, input int tk);
    id_valid    = (v != 0);
    id_rs1      = 4'(rs1);
    id_rs1_used = (u1 != 0);
    id_rs2      = 4'(rs2);
    id_rs2_used = (u2 != 0);
    id_rd       = 4'(rd);
    id_wr       = (wr != 0);
    id_load     = (ld != 0);
    id_mc       = (mc != 0);
    id_branch   = (br != 0);
    id_taken    = (tk != 0);
    #2;
  endtask

  task automatic id_nop();
    id_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    id_nop();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    id_ins(1, 1, 1, 2, 1, 3, 0, 0, 0, 1, 1);  // taken branch held in decode
    @(posedge clk);
    #3;
    n_vec++; if (stall_if !== 1'b0)  begin n_err++; $display("FAIL rst_stall: got %0b want 0", stall_if); end
    n_vec++; if (bubble_ex !== 1'b0) begin n_err++; $display("FAIL rst_bubble: got %0b want 0", bubble_ex); end
    n_vec++; if (flush_id !== 1'b0)  begin n_err++; $display("FAIL rst_flush: got %0b want 0", flush_id); end
    n_vec++; if (ex_hold !== 1'b0)   begin n_err++; $display("FAIL rst_hold: got %0b want 0", ex_hold); end
    n_vec++; if (mc_busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %0b want 0", mc_busy); end
    n_vec++; if (fwd_a_sel !== 2'd0) begin n_err++; $display("FAIL rst_fwd_a: got %0d want 0", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'd0) begin n_err++; $display("FAIL rst_fwd_b: got %0d want 0", fwd_b_sel); end
    n_vec++; if (perf_stalls !== 32'd0)  begin n_err++; $display("FAIL rst_pstall: got %0d want 0", perf_stalls); end
    n_vec++; if (perf_flushes !== 32'd0) begin n_err++; $display("FAIL rst_pflush: got %0d want 0", perf_flushes); end
    $display("test_reset: reset state checked");
  endtask

  task automatic test_forward();
    // ADD r3 ; SUB r4=r3-r2 back to back -> MEM forward on A
    do_reset();
    id_ins(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
    tick();
    id_ins(1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0);
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL fwd_nostall: got %0b want 0", stall_if); end
    tick();
    id_nop();
    n_vec++; if (fwd_a_sel !== 2'd2) begin n_err++; $display("FAIL fwd_mem_a: got %0d want 2", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'd0) begin n_err++; $display("FAIL fwd_mem_b: got %0d want 0", fwd_b_sel); end
    // ADD r3 ; OR r6 ; SUB r4=r3-r2 -> WB forward on A
    do_reset();
    id_ins(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
    tick();
    id_ins(1, 7, 1, 8, 1, 6, 1, 0, 0, 0, 0);
    tick();
    id_ins(1, 3, 1, 2, 1, 4, 1, 0, 0, 0, 0);
    tick();
    id_nop();
    n_vec++; if (fwd_a_sel !== 2'd1) begin n_err++; $display("FAIL fwd_wb_a: got %0d want 1", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'd0) begin n_err++; $display("FAIL fwd_wb_b: got %0d want 0", fwd_b_sel); end
    // ADD r3 ; ADD r3 ; SUB r3,r3 -> younger (MEM) wins on both
    do_reset();
    id_ins(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0);
    tick();
    id_ins(1, 5, 1, 6, 1, 3, 1, 0, 0, 0, 0);
    tick();
    id_ins(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0);
    tick();
    id_nop();
    n_vec++; if (fwd_a_sel !== 2'd2) begin n_err++; $display("FAIL fwd_prio_a: got %0d want 2", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'd2) begin n_err++; $display("FAIL fwd_prio_b: got %0d want 2", fwd_b_sel); end
    $display("test_forward: MEM/WB forwarding checked");
  endtask

  task automatic test_load_use();
    do_reset();
    id_ins(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0);   // LOAD r5
    tick();
    id_ins(1, 6, 1, 5, 1, 7, 1, 0, 0, 0, 0);   // ADD r7=r6+r5
    n_vec++; if (stall_if !== 1'b1)  begin n_err++; $display("FAIL lu_stall: got %0b want 1", stall_if); end
    n_vec++; if (bubble_ex !== 1'b1) begin n_err++; $display("FAIL lu_bubble: got %0b want 1", bubble_ex); end
    n_vec++; if (flush_id !== 1'b0)  begin n_err++; $display("FAIL lu_flush: got %0b want 0", flush_id); end
    tick();                                    // ADD still in decode
    n_vec++; if (stall_if !== 1'b0)  begin n_err++; $display("FAIL lu_stall2: got %0b want 0", stall_if); end
    n_vec++; if (bubble_ex !== 1'b0) begin n_err++; $display("FAIL lu_bubble2: got %0b want 0", bubble_ex); end
    tick();
    id_nop();
    n_vec++; if (fwd_b_sel !== 2'd1) begin n_err++; $display("FAIL lu_fwd_b: got %0d want 1", fwd_b_sel); end
    n_vec++; if (fwd_a_sel !== 2'd0) begin n_err++; $display("FAIL lu_fwd_a: got %0d want 0", fwd_a_sel); end
    $display("test_load_use: single stall then WB forward checked");
  endtask

  task automatic test_multicycle();
    do_reset();
    id_ins(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);   // X writes r1
    tick();
    id_ins(1, 1, 1, 2, 1, 8, 1, 0, 1, 0, 0);   // MUL r8=r1*r2
    n_vec++; if (ex_hold !== 1'b0) begin n_err++; $display("FAIL mc_pre_hold: got %0b want 0", ex_hold); end
    tick();
    id_ins(1, 10, 1, 11, 1, 9, 1, 0, 0, 0, 0); // ADD1 r9
    n_vec++; if (ex_hold !== 1'b1)  begin n_err++; $display("FAIL mc_hold1: got %0b want 1", ex_hold); end
    n_vec++; if (mc_busy !== 1'b1)  begin n_err++; $display("FAIL mc_busy1: got %0b want 1", mc_busy); end
    n_vec++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL mc_stall1: got %0b want 1", stall_if); end
    n_vec++; if (bubble_ex !== 1'b0) begin n_err++; $display("FAIL mc_bubble1: got %0b want 0", bubble_ex); end
    n_vec++; if (fwd_a_sel !== 2'd2) begin n_err++; $display("FAIL mc_fwd1: got %0d want 2", fwd_a_sel); end
    tick();
    n_vec++; if (ex_hold !== 1'b1)  begin n_err++; $display("FAIL mc_hold2: got %0b want 1", ex_hold); end
    n_vec++; if (mc_busy !== 1'b1)  begin n_err++; $display("FAIL mc_busy2: got %0b want 1", mc_busy); end
    n_vec++; if (fwd_a_sel !== 2'd1) begin n_err++; $display("FAIL mc_fwd2: got %0d want 1", fwd_a_sel); end
    tick();                                    // counter reads 0: MUL's last EX cycle
    n_vec++; if (ex_hold !== 1'b0)  begin n_err++; $display("FAIL mc_hold3: got %0b want 0", ex_hold); end
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL mc_stall3: got %0b want 0", stall_if); end
    n_vec++; if (fwd_a_sel !== 2'd0) begin n_err++; $display("FAIL mc_fwd3: got %0d want 0", fwd_a_sel); end
    tick();
    id_ins(1, 9, 1, 8, 1, 12, 1, 0, 0, 0, 0);  // ADD2 r12=r9+r8
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL mc_add2_stall: got %0b want 0", stall_if); end
    tick();
    id_nop();
    n_vec++; if (fwd_a_sel !== 2'd2) begin n_err++; $display("FAIL mc_order_a: got %0d want 2", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'd1) begin n_err++; $display("FAIL mc_order_b: got %0d want 1", fwd_b_sel); end
    $display("test_multicycle: MUL occupancy and ordering checked");
  endtask

  task automatic test_branch();
    do_reset();
    id_ins(1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 1);   // taken branch, no dependency
    n_vec++; if (flush_id !== 1'b1) begin n_err++; $display("FAIL br_flush0: got %0b want 1", flush_id); end
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL br_stall0: got %0b want 0", stall_if); end
    tick();
    id_ins(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);   // ADD r4
    n_vec++; if (flush_id !== 1'b0) begin n_err++; $display("FAIL br_flush1: got %0b want 0", flush_id); end
    tick();
    id_ins(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 1);   // branch on r4
    n_vec++; if (stall_if !== 1'b1)  begin n_err++; $display("FAIL br_ex_stall: got %0b want 1", stall_if); end
    n_vec++; if (bubble_ex !== 1'b1) begin n_err++; $display("FAIL br_ex_bubble: got %0b want 1", bubble_ex); end
    n_vec++; if (flush_id !== 1'b0)  begin n_err++; $display("FAIL br_ex_flush: got %0b want 0", flush_id); end
    tick();
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL br_ex_clear: got %0b want 0", stall_if); end
    n_vec++; if (flush_id !== 1'b1) begin n_err++; $display("FAIL br_ex_late_flush: got %0b want 1", flush_id); end
    tick();
    id_ins(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);   // LOAD r5
    tick();
    id_ins(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 1);   // branch on r5
    n_vec++; if (stall_if !== 1'b1) begin n_err++; $display("FAIL br_ld_stall1: got %0b want 1", stall_if); end
    tick();
    n_vec++; if (stall_if !== 1'b1)  begin n_err++; $display("FAIL br_ld_stall2: got %0b want 1", stall_if); end
    n_vec++; if (bubble_ex !== 1'b1) begin n_err++; $display("FAIL br_ld_bubble2: got %0b want 1", bubble_ex); end
    n_vec++; if (flush_id !== 1'b0)  begin n_err++; $display("FAIL br_ld_flush2: got %0b want 0", flush_id); end
    tick();
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL br_ld_clear: got %0b want 0", stall_if); end
    n_vec++; if (flush_id !== 1'b1) begin n_err++; $display("FAIL br_ld_flush3: got %0b want 1", flush_id); end
    tick();
    id_nop();
`ifdef HZC_PERF_EN
    n_vec++; if (perf_stalls !== 32'd3)  begin n_err++; $display("FAIL perf_stalls: got %0d want 3", perf_stalls); end
    n_vec++; if (perf_flushes !== 32'd3) begin n_err++; $display("FAIL perf_flushes: got %0d want 3", perf_flushes); end
`else
    n_vec++; if (perf_stalls !== 32'd0)  begin n_err++; $display("FAIL perf_stalls_off: got %0d want 0", perf_stalls); end
    n_vec++; if (perf_flushes !== 32'd0) begin n_err++; $display("FAIL perf_flushes_off: got %0d want 0", perf_flushes); end
`endif
    $display("test_branch: flush and branch-hazard stalls checked");
  endtask

  task automatic test_r0_zero();
    do_reset();
    id_ins(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);   // LOAD r0
    tick();
    id_ins(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);   // SUB r0=r0-r0
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL r0_nostall: got %0b want 0", stall_if); end
    tick();
    id_ins(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0);   // ADD r6=r0+r0
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL r0_nostall2: got %0b want 0", stall_if); end
    tick();
    id_nop();
    n_vec++; if (fwd_a_sel !== 2'd0) begin n_err++; $display("FAIL r0_fwd_a: got %0d want 0", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'd0) begin n_err++; $display("FAIL r0_fwd_b: got %0d want 0", fwd_b_sel); end
    $display("test_r0_zero: r0 writes ignored");
  endtask

  task automatic test_reset_mid_mc();
    do_reset();
    id_ins(1, 1, 1, 2, 1, 8, 1, 0, 1, 0, 0);   // MUL
    tick();
    id_ins(1, 8, 1, 0, 0, 9, 1, 0, 0, 1, 1);   // dependent taken branch waits
    n_vec++; if (ex_hold !== 1'b1) begin n_err++; $display("FAIL rm_hold_pre: got %0b want 1", ex_hold); end
    reset = 1'b0;
    #1;
    n_vec++; if (ex_hold !== 1'b0)  begin n_err++; $display("FAIL rm_hold: got %0b want 0", ex_hold); end
    n_vec++; if (mc_busy !== 1'b0)  begin n_err++; $display("FAIL rm_busy: got %0b want 0", mc_busy); end
    n_vec++; if (stall_if !== 1'b0) begin n_err++; $display("FAIL rm_stall: got %0b want 0", stall_if); end
    n_vec++; if (flush_id !== 1'b0) begin n_err++; $display("FAIL rm_flush: got %0b want 0", flush_id); end
    n_vec++; if (perf_stalls !== 32'd0) begin n_err++; $display("FAIL rm_pstall: got %0d want 0", perf_stalls); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    id_nop();
    n_vec++; if (ex_hold !== 1'b0) begin n_err++; $display("FAIL rm_rel_hold: got %0b want 0", ex_hold); end
    tick();
    n_vec++; if (mc_busy !== 1'b0) begin n_err++; $display("FAIL rm_rel_busy: got %0b want 0", mc_busy); end
    $display("test_reset_mid_mc: async reset during hold checked");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_multicycle();
    test_branch();
    test_r0_zero();
    test_reset_mid_mc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the pipelined CPU. It replaces the fixed 16-register, combinational-only hazard detection and forwarding logic. It keeps its own shadow records of the EX, MEM and WB stages, so it can:
- generate stall, bubble, flush and forward-select signals for any register-file size;
- add multi-cycle EX operations (e.g. MUL) with a configurable latency.

It sits beside the decode stage and drives the PC register, the Fetch-Decode register, the Decode-Execute register and the ALU forwarding muxes.

## Interface
- NREGS, 16, architectural register count (power of two, ≥2)
- RW, $clog2(NREGS), register-index width
- MC_LAT, 3, EX occupancy in cycles of a multi-cycle op (≥2)
- R0_ZERO, 1, when 1, writes to register 0 never create dependencies

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs1, id_rs2  in  RW  decode source indices
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  RW  decode destination
- id_wr  in  1  instruction writes the register file
- id_load  in  1  instruction is a RAM load
- id_mc  in  1  instruction is multi-cycle
- id_branch  in  1  branch resolved in decode
- id_taken  in  1  branch comparator result
- stall_if  out  1  hold PC and Fetch-Decode
- bubble_ex  out  1  load zero controls into Decode-Execute
- flush_id  out  1  zero the Fetch-Decode instruction
- ex_hold  out  1  hold Decode-Execute (multi-cycle in progress)
- fwd_a_sel, fwd_b_sel  out  2  0 = register file, 1 = WB data, 2 = MEM ALU result
- mc_busy  out  1  multi-cycle counter nonzero
- perf_stalls, perf_flushes  out  32  performance counters (see Configuration)

## Operation
- Shadow records hold {valid, rd, wr, load, rs1, rs2, rs1_used, rs2_used} for EX, and {valid, rd, wr, load} for MEM and WB.
- A record matches source s when: valid & wr & rd==s & used(s) & !(R0_ZERO & rd==0).
- Load-use hazard: EX record is a load and matches an ID source.
  - Drives stall_if=1 and bubble_ex=1 for one cycle.
- Branch hazard: id_branch and either the EX record matches, or the MEM record is a load and matches.
  - Drives stall_if=1 and bubble_ex=1 until the condition clears.
- Flush: flush_id = id_valid & id_branch & id_taken & !stall_if.
- Multi-cycle op:
  - When an id_mc instruction advances into EX, the counter loads MC_LAT-1.
  - While the counter is nonzero: ex_hold=1, stall_if=1, and a bubble shifts into MEM. The EX record is kept.
  - The counter decrements each cycle. Advance resumes on the cycle it reads 0.
- Forwarding for the EX record sources:
  - MEM match selects 2; otherwise WB match selects 1; otherwise 0.
  - MEM takes priority over WB.
  - A MEM record that is a load is never a forward source; the load-use stall guarantees it is not needed.
- Record advance when not held:
  - WB←MEM and MEM←EX.
  - EX←ID, or an invalid record if bubble_ex or !id_valid.
- Simultaneous events:
  - Multi-cycle hold has priority over every other hazard.
  - A stall suppresses the flush.
  - Load-use and branch hazards in the same cycle give a single stall.

## Timing
- Reset (asynchronous, reset=0):
  - All records invalid and the counter 0.
  - All outputs 0, perf counters 0.
- Forward selects, stall_if, bubble_ex, flush_id and ex_hold are combinational from registered records plus ID inputs. They are valid in the same cycle.
- A load-use dependency costs exactly 1 stall cycle. A multi-cycle op occupies EX for MC_LAT cycles.
- A reset assertion mid-hold clears the counter immediately. No stale ex_hold appears after release.

## Configuration
- HZC_PERF_EN defined:
  - perf_stalls counts cycles with stall_if=1.
  - perf_flushes counts cycles with flush_id=1.
  - Both are 32-bit, saturate at all-ones, and clear on reset.
- HZC_PERF_EN undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package hzc_pkg holds:
  - the stage-record struct (parameterised by RW through a typedef in the module);
  - the forward-select enum FWD_REG=0, FWD_WB=1, FWD_MEM=2.
- One sub-module, hzc_fwd_sel: a combinational per-operand comparator and priority mux. It is instantiated twice (A and B).

## Test plan
Each scenario is written as stimulus → required response.
- ADD r3 issued, then SUB using rs1=r3 in the next cycle → fwd_a_sel=2 in SUB's EX cycle; fwd_a_sel=1 if one instruction separates them.
- LOAD r5, then ADD using rs2=r5 → stall_if=bubble_ex=1 for exactly 1 cycle, then fwd_b_sel=1.
- MUL with MC_LAT=3, then 2 ADDs → ex_hold=mc_busy=1 for 2 cycles; the MEM records contain 2 bubbles; the ADDs follow in order.
- Taken branch with no dependency → flush_id=1 for 1 cycle; the same branch behind a matching EX write → stall first, with flush_id only after the stall clears.
- R0_ZERO=1, write r0, then read r0 → fwd selects 0 and no stall.
- reset=0 mid-MUL → all outputs 0 immediately; counter 0 after release; with HZC_PERF_EN, perf_stalls=0.
